// File: rtl/conv_pkg.sv
// Shared types and constants for the feature-map datapath.
// Defaults size an 8x8 map with 8-bit words.
package conv_pkg;

  localparam int DEFAULT_IMG_WIDTH = 8;
  localparam int DEFAULT_IMG_HEIGHT = 8;
  localparam int DEFAULT_BITS_PER_COORDINATE_IN = 4;
  localparam int DEFAULT_OUT_CHANNELS = 2;
  localparam int DEFAULT_BITS_PER_NEURON = 4;

  localparam int FMAP_WORD_BITS =
    DEFAULT_OUT_CHANNELS * DEFAULT_BITS_PER_NEURON;

  localparam int ADDR_BITS =
    $clog2(DEFAULT_IMG_WIDTH * DEFAULT_IMG_HEIGHT);

  localparam int REQ_CONV = 0;
  localparam int REQ_SCAN = 1;

  typedef struct packed {
    logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] x;
    logic [DEFAULT_BITS_PER_COORDINATE_IN-1:0] y;
  } vec2_t;

  typedef logic [FMAP_WORD_BITS-1:0] fmap_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWNED,
    ST_DRAIN
  } arb_state_e;

  function automatic int addr_bits(int w, int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester
// at or after the pointer wins, one-hot result.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [PTR_BITS-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  win_o
);

  logic found;
  int   idx;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[idx]) begin
        win_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmap_arbiter.sv
// Burst arbiter sharing one feature-map BRAM between
// the convolution engine and the readout/leak scanner.
module fmap_arbiter
  import conv_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
  parameter int COORD_BITS = DEFAULT_BITS_PER_COORDINATE_IN,
  parameter int WORD_BITS  =
    DEFAULT_OUT_CHANNELS * DEFAULT_BITS_PER_NEURON,
  localparam int AW = addr_bits(IMG_WIDTH, IMG_HEIGHT),
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req,
  output logic [NUM_REQ-1:0]                 gnt,
  input  logic [NUM_REQ-1:0]                 rd_en,
  input  vec2_t [NUM_REQ-1:0]                rd_coord,
  output logic [NUM_REQ-1:0][WORD_BITS-1:0]  rd_data,
  input  logic [NUM_REQ-1:0]                 wr_en,
  input  vec2_t [NUM_REQ-1:0]                wr_coord,
  input  logic [NUM_REQ-1:0][WORD_BITS-1:0]  wr_data,
  output logic [AW-1:0]                      mem_raddr,
  output logic                               mem_ren,
  input  logic [WORD_BITS-1:0]               mem_rdata,
  output logic [AW-1:0]                      mem_waddr,
  output logic                               mem_wen,
  output logic [WORD_BITS-1:0]               mem_wdata
);

  arb_state_e           state_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IW-1:0]        owner_q;
  logic [IW-1:0]        last_q;
  logic                 rd_vld_q;
  logic                 byp_q;
  logic [WORD_BITS-1:0] byp_data_q;

  logic [IW-1:0]        ptr;
  logic [NUM_REQ-1:0]   win;
  logic [IW-1:0]        win_idx;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 rd_in;
  logic                 wr_in;
  logic [AW-1:0]        ra;
  logic [AW-1:0]        wa;
  logic [WORD_BITS-1:0] rd_word;

  function automatic int cx(vec2_t c);
    return int'(COORD_BITS'(c.x));
  endfunction

  function automatic int cy(vec2_t c);
    return int'(COORD_BITS'(c.y));
  endfunction

  function automatic logic inb(vec2_t c);
    return (cx(c) < IMG_WIDTH) && (cy(c) < IMG_HEIGHT);
  endfunction

  function automatic logic [AW-1:0] lin(vec2_t c);
    return AW'(cy(c) * IMG_WIDTH + cx(c));
  endfunction

  always_comb begin
    ptr = (last_q == IW'(NUM_REQ - 1))
        ? '0 : last_q + 1'b1;
  end

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .PTR_BITS (IW)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr),
    .win_o (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = IW'(i);
    end
  end

  // Only the owner reaches the BRAM; DRAIN admits the trailing write only.
  always_comb begin
    rd_acc = !rst && (state_q == ST_OWNED) && rd_en[owner_q];
    wr_acc = !rst && (state_q != ST_IDLE) && wr_en[owner_q];
    rd_in  = inb(rd_coord[owner_q]);
    wr_in  = inb(wr_coord[owner_q]);
    ra     = lin(rd_coord[owner_q]);
    wa     = lin(wr_coord[owner_q]);
  end

  always_comb begin
    mem_ren   = rd_acc && rd_in;
    mem_wen   = wr_acc && wr_in;
    mem_raddr = mem_ren ? ra : '0;
    mem_waddr = mem_wen ? wa : '0;
    mem_wdata = mem_wen ? wr_data[owner_q] : '0;
  end

  always_comb begin
    rd_word = '0;
    if (rst)           rd_word = '0;
    else if (byp_q)    rd_word = byp_data_q;
    else if (rd_vld_q) rd_word = mem_rdata;
    for (int i = 0; i < NUM_REQ; i++) begin
      rd_data[i] = rd_word;
    end
  end

  assign gnt = gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      rd_vld_q   <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_vld_q   <= mem_ren;
      byp_q      <= mem_ren && mem_wen && (ra == wa);
      byp_data_q <= mem_wdata;
      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q   <= win;
            owner_q <= win_idx;
            last_q  <= win_idx;
            state_q <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (!req[owner_q]) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_arbiter.sv
// Bench for fmap_arbiter: directed table, drain burst,
// then random traffic against a reference model.
module tb_fmap_arbiter;
  import conv_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [1:0]       rd_en;
  vec2_t [1:0]      rd_coord;
  logic [1:0][7:0]  rd_data;
  logic [1:0]       wr_en;
  vec2_t [1:0]      wr_coord;
  logic [1:0][7:0]  wr_data;
  logic [5:0]       mem_raddr;
  logic             mem_ren;
  logic [7:0]       mem_rdata;
  logic [5:0]       mem_waddr;
  logic             mem_wen;
  logic [7:0]       mem_wdata;

  always #5 clk = ~clk;

  fmap_arbiter #(
    .NUM_REQ    (2),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COORD_BITS (4),
    .WORD_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .rd_en     (rd_en),
    .rd_coord  (rd_coord),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_coord  (wr_coord),
    .wr_data   (wr_data),
    .mem_raddr (mem_raddr),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata),
    .mem_waddr (mem_waddr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata)
  );

  // Read-first BRAM: a colliding read returns the old word.
  logic [7:0] bram [64];
  logic       bram_clr;

  always @(posedge clk) begin
    if (bram_clr) begin
      for (int i = 0; i < 64; i++) bram[i] <= '0;
    end else if (mem_wen) begin
      bram[mem_waddr] <= mem_wdata;
    end
    if (mem_ren) mem_rdata <= bram[mem_raddr];
  end

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  task automatic set_in(logic r, logic [1:0] rq,
                        logic [1:0] re, int rx, int ry,
                        logic [1:0] we, int wx, int wy,
                        logic [7:0] wd);
    rst = r;
    req = rq;
    rd_en = re;
    wr_en = we;
    for (int i = 0; i < 2; i++) begin
      rd_coord[i].x = 4'(rx);
      rd_coord[i].y = 4'(ry);
      wr_coord[i].x = 4'(wx);
      wr_coord[i].y = 4'(wy);
      wr_data[i] = wd;
    end
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] rde;
    int         rx;
    int         ry;
    logic [1:0] wre;
    int         wx;
    int         wy;
    logic [7:0] wd;
    logic [1:0] gnt;
    logic       ren;
    int         ra;
    logic       wen;
    int         wa;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[18];

  // Reference model state
  int         m_owner;
  bit         m_drain;
  int         m_last;
  logic [7:0] m_rd;
  logic [7:0] shadow [64];

  function automatic bit in_b(vec2_t c);
    return (int'(c.x) < W) && (int'(c.y) < H);
  endfunction

  function automatic int lin(vec2_t c);
    return int'(c.y) * W + int'(c.x);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_drain = 0;
    m_last  = 1;
    m_rd    = '0;
  endtask

  task automatic rand_cycle();
    int   ow;
    int   ar;
    int   aw;
    bit   ok_r;
    bit   ok_w;
    logic [7:0] wd;
    @(negedge clk);
    rst = ($urandom_range(0, 63) == 0);
    for (int i = 0; i < 2; i++) begin
      if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      rd_en[i] = $urandom_range(0, 1) == 1;
      wr_en[i] = $urandom_range(0, 1) == 1;
      rd_coord[i].x = 4'($urandom_range(0, 9));
      rd_coord[i].y = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) wr_coord[i] = rd_coord[i];
      else begin
        wr_coord[i].x = 4'($urandom_range(0, 9));
        wr_coord[i].y = 4'($urandom_range(0, 9));
      end
      wr_data[i] = 8'($urandom);
    end
    #1;
    ow = (m_owner < 0) ? 0 : m_owner;
    ok_r = !rst && m_owner >= 0 && !m_drain &&
           rd_en[ow] && in_b(rd_coord[ow]);
    ok_w = !rst && m_owner >= 0 &&
           wr_en[ow] && in_b(wr_coord[ow]);
    ar = lin(rd_coord[ow]);
    aw = lin(wr_coord[ow]);
    wd = wr_data[ow];
    chk("rnd_gnt", int'(gnt),
        (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("rnd_ren", int'(mem_ren), int'(ok_r));
    chk("rnd_wen", int'(mem_wen), int'(ok_w));
    if (ok_r) chk("rnd_raddr", int'(mem_raddr), ar);
    if (ok_w) begin
      chk("rnd_waddr", int'(mem_waddr), aw);
      chk("rnd_wdata", int'(mem_wdata), int'(wd));
    end
    for (int i = 0; i < 2; i++) begin
      chk("rnd_rdata", int'(rd_data[i]),
          rst ? 0 : int'(m_rd));
    end
    if (rst) begin
      model_reset();
    end else begin
      if (ok_r) m_rd = (ok_w && aw == ar) ? wd : shadow[ar];
      else      m_rd = '0;
      if (ok_w) shadow[aw] = wd;
      if (m_owner < 0) begin
        for (int k = 1; k <= 2; k++) begin
          if (m_owner < 0 && req[(m_last + k) % 2]) begin
            m_owner = (m_last + k) % 2;
            m_last  = m_owner;
          end
        end
      end else if (m_drain) begin
        m_owner = -1;
        m_drain = 0;
      end else if (!req[m_owner]) begin
        m_drain = 1;
      end
    end
  endtask

  initial begin
    int nwr;
    set_in(1'b1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00);
    bram_clr = 1'b1;
    repeat (2) @(posedge clk);

    //          rst req  rde  rx ry wre  wx wy wd     gnt  ren ra wen wa rd
    tbl[0]  = '{1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00};
    tbl[1]  = '{0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00};
    tbl[2]  = '{0, 2'b11, 2'b01, 2, 3, 2'b01, 2, 3, 8'hEE, 2'b00, 0, 0, 0, 0, 8'h00};
    tbl[3]  = '{0, 2'b11, 2'b00, 0, 0, 2'b01, 2, 3, 8'h5C, 2'b01, 0, 0, 1, 26, 8'h00};
    tbl[4]  = '{0, 2'b11, 2'b01, 2, 3, 2'b00, 0, 0, 8'h00, 2'b01, 1, 26, 0, 0, 8'h00};
    tbl[5]  = '{0, 2'b11, 2'b01, 1, 1, 2'b01, 1, 1, 8'hAB, 2'b01, 1, 9, 1, 9, 8'h5C};
    tbl[6]  = '{0, 2'b11, 2'b01, 8, 0, 2'b10, 0, 0, 8'hFF, 2'b01, 0, 0, 0, 0, 8'hAB};
    tbl[7]  = '{0, 2'b11, 2'b10, 1, 1, 2'b00, 0, 0, 8'h00, 2'b01, 0, 0, 0, 0, 8'h00};
    tbl[8]  = '{0, 2'b11, 2'b01, 1, 1, 2'b00, 0, 0, 8'h00, 2'b01, 1, 9, 0, 0, 8'h00};
    tbl[9]  = '{0, 2'b10, 2'b01, 2, 3, 2'b00, 0, 0, 8'h00, 2'b01, 1, 26, 0, 0, 8'hAB};
    tbl[10] = '{0, 2'b10, 2'b01, 2, 3, 2'b01, 3, 0, 8'h11, 2'b01, 0, 0, 1, 3, 8'h5C};
    tbl[11] = '{0, 2'b10, 2'b00, 0, 0, 2'b01, 3, 0, 8'h22, 2'b00, 0, 0, 0, 0, 8'h00};
    tbl[12] = '{0, 2'b10, 2'b10, 3, 0, 2'b00, 0, 0, 8'h00, 2'b10, 1, 3, 0, 0, 8'h00};
    tbl[13] = '{1, 2'b10, 2'b00, 0, 0, 2'b10, 3, 3, 8'h33, 2'b10, 0, 0, 0, 0, 8'h00};
    tbl[14] = '{0, 2'b11, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00};
    tbl[15] = '{0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00, 2'b01, 0, 0, 0, 0, 8'h00};
    tbl[16] = '{0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00, 2'b01, 0, 0, 0, 0, 8'h00};
    tbl[17] = '{0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00, 2'b00, 0, 0, 0, 0, 8'h00};

    @(negedge clk);
    bram_clr = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) @(negedge clk);
      set_in(tbl[i].rst, tbl[i].req, tbl[i].rde,
             tbl[i].rx, tbl[i].ry, tbl[i].wre,
             tbl[i].wx, tbl[i].wy, tbl[i].wd);
      #1;
      chk($sformatf("t%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
      chk($sformatf("t%0d_ren", i), int'(mem_ren), int'(tbl[i].ren));
      chk($sformatf("t%0d_wen", i), int'(mem_wen), int'(tbl[i].wen));
      if (tbl[i].ren)
        chk($sformatf("t%0d_raddr", i), int'(mem_raddr), tbl[i].ra);
      if (tbl[i].wen) begin
        chk($sformatf("t%0d_waddr", i), int'(mem_waddr), tbl[i].wa);
        chk($sformatf("t%0d_wdata", i), int'(mem_wdata), int'(tbl[i].wd));
      end
      chk($sformatf("t%0d_rd0", i), int'(rd_data[0]), int'(tbl[i].rd));
      chk($sformatf("t%0d_rd1", i), int'(rd_data[1]), int'(tbl[i].rd));
    end

    // Nine reads, each write one cycle behind; last write lands in DRAIN.
    @(negedge clk);
    set_in(1'b0, 2'b01, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00);
    #1;
    chk("burst_pre_gnt", int'(gnt), 0);
    nwr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_in(1'b0, (k < 8) ? 2'b01 : 2'b00,
             2'b01, (32 + k) % 8, (32 + k) / 8,
             (k >= 1) ? 2'b01 : 2'b00,
             (16 + k - 1) % 8, (16 + k - 1) / 8,
             8'(8'h40 + k));
      #1;
      chk($sformatf("burst%0d_gnt", k), int'(gnt), 1);
      chk($sformatf("burst%0d_ren", k), int'(mem_ren), int'(k < 9));
      if (k < 9)
        chk($sformatf("burst%0d_raddr", k), int'(mem_raddr), 32 + k);
      chk($sformatf("burst%0d_wen", k), int'(mem_wen), int'(k >= 1));
      if (k >= 1) begin
        chk($sformatf("burst%0d_waddr", k), int'(mem_waddr), 16 + k - 1);
        chk($sformatf("burst%0d_wdata", k), int'(mem_wdata), 'h40 + k);
      end
      if (mem_wen) nwr++;
    end
    @(negedge clk);
    set_in(1'b0, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00);
    #1;
    chk("burst_post_gnt", int'(gnt), 0);
    chk("burst_writes", nwr, 9);

    // Random traffic from a clean reset and a cleared BRAM.
    @(negedge clk);
    set_in(1'b1, 2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 8'h00);
    bram_clr = 1'b1;
    model_reset();
    for (int i = 0; i < 64; i++) shadow[i] = '0;
    @(posedge clk);
    #1;
    bram_clr = 1'b0;
    for (int n = 0; n < 3000; n++) rand_cycle();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
